// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer
// Two-bank ping-pong buffer that takes one parallel complex FFT/IFFT frame per
// handshake and replays it as one complex sample per cycle, natural or
// bit-reversed bin order, with a per-frame FFT/IFFT mode tag.
module fft_frame_serializer #(
  parameter int N_PTS  = 8,
  parameter int DW     = 16,
  parameter int BITREV = 0,
  localparam int IW    = $clog2(N_PTS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                frm_valid,
  output logic                                frm_ready,
  input  logic [N_PTS-1:0][1:0][DW-1:0]       frm_data,
  input  logic                                frm_mode,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [DW-1:0]                out_re,
  output logic signed [DW-1:0]                out_im,
  output logic [IW-1:0]                       out_idx,
  output logic                                out_last,
  output logic                                out_mode
);

  logic [1:0][N_PTS-1:0][1:0][DW-1:0] bank_q;
  logic [1:0]                         mode_q;
  logic                               wr_ptr_q, wr_ptr_d;
  logic                               rd_ptr_q, rd_ptr_d;
  logic [1:0]                         cnt_q, cnt_d;
  logic [IW-1:0]                      seq_q, seq_d;

  logic          accept;
  logic          pop;
  logic          last_pop;
  logic [IW-1:0] rd_idx;

  // Bin index for the current sequence position: identity or bit reversal.
  function automatic logic [IW-1:0] map_idx(input logic [IW-1:0] s);
    logic [IW-1:0] r;
    r = s;
    if (BITREV != 0) begin
      for (int unsigned i = 0; i < IW; i++) begin
        r[i] = s[IW-1-i];
      end
    end
    return r;
  endfunction

  // Handshake qualifiers; both sides are masked during reset.
  always_comb begin
    frm_ready = !reset && (cnt_q < 2'd2);
    out_valid = !reset && (cnt_q != 2'd0);
    accept    = frm_valid && frm_ready;
    pop       = out_valid && out_ready;
    last_pop  = pop && (seq_q == IW'(N_PTS - 1));
    rd_idx    = map_idx(seq_q);
  end

  // Next-state for pointers, occupancy count and sample sequence.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    if (accept) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      if (last_pop) begin
        seq_d    = '0;
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        seq_d = seq_q + 1'b1;
      end
    end
    unique case ({accept, last_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register with synchronous reset; in-flight frames are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      seq_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
    end
  end

  // Frame storage: only the free bank at wr_ptr is ever written.
  always_ff @(posedge clk) begin
    if (accept) begin
      bank_q[wr_ptr_q] <= frm_data;
      mode_q[wr_ptr_q] <= frm_mode;
    end
  end

  // Output mux; all sample outputs are forced to zero when no sample is valid.
  always_comb begin
    out_re   = '0;
    out_im   = '0;
    out_idx  = '0;
    out_last = 1'b0;
    out_mode = 1'b0;
    if (out_valid) begin
      out_re   = bank_q[rd_ptr_q][rd_idx][0];
      out_im   = bank_q[rd_ptr_q][rd_idx][1];
      out_idx  = rd_idx;
      out_last = (seq_q == IW'(N_PTS - 1));
      out_mode = mode_q[rd_ptr_q];
    end
  end

endmodule
